// File: rtl/apb_timer_completer_pkg.sv
// Shared definitions for the APB timer completer: register offsets, CTRL bit
// positions, FSM state encoding and the offset/access legality check.
package apb_timer_completer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    // Word indices, i.e. PADDR[5:2]
    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_LOAD     = 4'h1;
    localparam logic [3:0] REG_COUNT    = 4'h2;
    localparam logic [3:0] REG_STATUS   = 4'h3;
    localparam logic [3:0] REG_PRESCALE = 4'h4;
    localparam logic [3:0] REG_SCRATCH  = 4'h5;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_EXPIRED   = 0;

    function automatic logic reg_error(input logic [3:0] idx, input logic wr);
        return (idx > REG_SCRATCH) || (wr && (idx == REG_COUNT));
    endfunction

endpackage

// File: rtl/apb_timer_completer_if.sv
// APB bus bundle between the LSU initiator bridge and the timer completer.
interface apb_timer_completer_if;
    // A transfer is a setup cycle (PSEL=1, PENABLE=0) followed by access cycles
    // (PSEL=1, PENABLE=1); it completes on the first access cycle with PREADY=1,
    // and PRDATA/PSLVERR are only meaningful while PREADY=1.
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_core.sv
// Prescaled down-counter: prescaler, COUNT and the EXPIRED flag.
module apb_timer_core #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               auto_reload,
    input  logic [PRESC_W-1:0] presc,
    input  logic               load_wr,
    input  logic [31:0]        load_value,
    input  logic [31:0]        reload_value,
    input  logic               presc_clr,
    input  logic               w1c,
    output logic [31:0]        count,
    output logic               expired,
    output logic               clear_en
);

    logic [PRESC_W-1:0] pcnt_q;
    logic [31:0]        count_q;
    logic               expired_q;
    logic               wrap;
    logic               tick;
    logic               expiry;

    // >= keeps the prescaler from running away if PRESCALE is lowered mid-count
    assign wrap     = pcnt_q >= presc;
    assign tick     = en && wrap && !load_wr;
    assign expiry   = tick && (count_q == 32'd0);
    assign clear_en = expiry && !auto_reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            if (load_wr || presc_clr) begin
                pcnt_q <= '0;
            end else if (en) begin
                pcnt_q <= wrap ? '0 : pcnt_q + 1'b1;
            end

            if (load_wr) begin
                count_q <= load_value;
            end else if (tick) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else if (auto_reload) begin
                    count_q <= reload_value;
                end
            end

            // Set wins over a same-edge write-1-to-clear
            if (expiry) begin
                expired_q <= 1'b1;
            end else if (w1c) begin
                expired_q <= 1'b0;
            end
        end
    end

    assign count   = count_q;
    assign expired = expired_q;

endmodule

// File: rtl/apb_timer_completer.sv
// APB completer hosting a prescaled down-counting timer with programmable wait
// states; PREADY is held until the initiator ends the access phase.
module apb_timer_completer
    import apb_timer_completer_pkg::*;
#(
    parameter logic [2:0] WAIT_STATES = 3'd1,
    parameter int         PRESC_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    apb_timer_completer_if.slave   apb,
    output logic                   irq,
    output apb_state_e             fsm_state
);

    apb_state_e         state_q, state_d;
    logic [2:0]         wcnt_q, wcnt_d;
    logic [3:0]         addr_q;
    logic               write_q;
    logic [31:0]        wdata_q;

    logic [31:0]        prdata_q;
    logic               pready_q;
    logic               pslverr_q;

    logic               ctrl_en_q, ctrl_ar_q, ctrl_ie_q;
    logic [31:0]        load_q;
    logic [PRESC_W-1:0] presc_q;
    logic [31:0]        scratch_q;
    logic               irq_q;

    logic               latch;
    logic               respond;
    logic [3:0]         acc_idx;
    logic               acc_write;
    logic [31:0]        acc_wdata;
    logic               acc_err;
    logic [31:0]        rdata;
    logic               commit;
    logic               wr_ctrl, wr_load, wr_status, wr_presc, wr_scratch;

    logic [31:0]        count;
    logic               expired;
    logic               clear_en;

    logic               unused_paddr_bits;
    assign unused_paddr_bits = ^{apb.PADDR[31:6], apb.PADDR[1:0]};

    // wcnt holds the number of PREADY=0 access cycles still to come after the
    // current one, so WAIT_STATES=0 must answer straight from the setup edge.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        latch     = 1'b0;
        respond   = 1'b0;
        acc_idx   = addr_q;
        acc_write = write_q;
        acc_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    latch     = 1'b1;
                    acc_idx   = apb.PADDR[5:2];
                    acc_write = apb.PWRITE;
                    acc_wdata = apb.PWDATA;
                    if (WAIT_STATES == 3'd0) begin
                        state_d = ST_RESP;
                        respond = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_STATES - 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 3'd0) begin
                    state_d = ST_RESP;
                    respond = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (!(apb.PSEL && apb.PENABLE)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (acc_idx)
            REG_CTRL:     rdata = {29'd0, ctrl_ie_q, ctrl_ar_q, ctrl_en_q};
            REG_LOAD:     rdata = load_q;
            REG_COUNT:    rdata = count;
            REG_STATUS:   rdata = {31'd0, expired};
            REG_PRESCALE: rdata = 32'(presc_q);
            REG_SCRATCH:  rdata = scratch_q;
            default:      rdata = '0;
        endcase
    end

    assign acc_err    = reg_error(acc_idx, acc_write);
    assign commit     = respond && acc_write && !acc_err;
    assign wr_ctrl    = commit && (acc_idx == REG_CTRL);
    assign wr_load    = commit && (acc_idx == REG_LOAD);
    assign wr_status  = commit && (acc_idx == REG_STATUS) && acc_wdata[STATUS_EXPIRED];
    assign wr_presc   = commit && (acc_idx == REG_PRESCALE);
    assign wr_scratch = commit && (acc_idx == REG_SCRATCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            if (latch) begin
                addr_q  <= apb.PADDR[5:2];
                write_q <= apb.PWRITE;
                wdata_q <= apb.PWDATA;
            end
            if (respond) begin
                pready_q  <= 1'b1;
                pslverr_q <= acc_err;
                prdata_q  <= (acc_write || acc_err) ? 32'd0 : rdata;
            end else if (state_d == ST_IDLE) begin
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_q <= 1'b0;
            ctrl_ar_q <= 1'b0;
            ctrl_ie_q <= 1'b0;
            load_q    <= '0;
            presc_q   <= '0;
            scratch_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            // A CTRL write overrides the timer's own EN clear on expiry
            if (wr_ctrl) begin
                ctrl_en_q <= acc_wdata[CTRL_EN];
                ctrl_ar_q <= acc_wdata[CTRL_AUTO_RELOAD];
                ctrl_ie_q <= acc_wdata[CTRL_IRQ_EN];
            end else if (clear_en) begin
                ctrl_en_q <= 1'b0;
            end
            if (wr_load) begin
                load_q <= acc_wdata;
            end
            if (wr_presc) begin
                presc_q <= acc_wdata[PRESC_W-1:0];
            end
            if (wr_scratch) begin
                scratch_q <= acc_wdata;
            end
            irq_q <= expired && ctrl_ie_q;
        end
    end

    apb_timer_core #(.PRESC_W(PRESC_W)) u_core (
        .clk          (clk),
        .rst          (rst),
        .en           (ctrl_en_q),
        .auto_reload  (ctrl_ar_q),
        .presc        (presc_q),
        .load_wr      (wr_load),
        .load_value   (acc_wdata),
        .reload_value (load_q),
        .presc_clr    (wr_ctrl && !ctrl_en_q && acc_wdata[CTRL_EN]),
        .w1c          (wr_status),
        .count        (count),
        .expired      (expired),
        .clear_en     (clear_en)
    );

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign irq         = irq_q;
    assign fsm_state   = state_q;

endmodule
